// File: rtl/contador_bcd_mux_pkg.sv
// Shared types and constants for the two-digit BCD counter with multiplexed display.
package contador_bcd_mux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    // Active-low digit enables driven onto the display commons.
    localparam logic [1:0] DIG_UNITS = 2'b10;
    localparam logic [1:0] DIG_TENS  = 2'b01;

    localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/contador_prescaler.sv
// Divides clk into a one-cycle tick every PRESCALE enabled cycles; holds while disabled.
module contador_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int W = $clog2(PRESCALE);
    localparam logic [W-1:0] LAST = W'(PRESCALE - 1);

    logic [W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Phase counter: cleared on request, wraps on tick, frozen when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (sync_clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/contador_bcd_mux.sv
// Two-digit BCD up/down counter with run/pause control and a time-multiplexed digit output.
//
// state | meaning
// IDLE  | stopped, count held at 00 after clear/reset, waits for start
// RUN   | prescaler advancing, count changes on each tick
// PAUSE | prescaler and count frozen, start resumes
module contador_bcd_mux
    import contador_bcd_mux_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int SCAN_DIV = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       up_dn,
    output logic [3:0] bcd_out,
    output logic [1:0] dig_sel,
    output logic       running,
    output logic       wrap
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    state_t      state, state_nxt;
    logic        run_en;
    logic        tick;
    logic [3:0]  units, tens, units_nxt, tens_nxt;
    logic        wrap_nxt;
    logic [SW-1:0] scan_cnt;
    logic        scan_edge;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state with clear > stop > start; counting is suppressed the cycle stop or clear is seen.
    always_comb begin
        state_nxt = state;
        run_en    = 1'b0;
        if (clear) begin
            state_nxt = IDLE;
        end else if (stop) begin
            if (state == RUN) state_nxt = PAUSE;
        end else begin
            run_en = (state == RUN);
            if (start && (state != RUN)) state_nxt = RUN;
        end
    end

    contador_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (run_en),
        .sync_clr (clear),
        .tick     (tick)
    );

    // Next BCD digits on a tick, with carry/borrow between digits and wrap detection.
    always_comb begin
        units_nxt = units;
        tens_nxt  = tens;
        wrap_nxt  = 1'b0;
        if (tick) begin
            if (up_dn) begin
                if (units == BCD_MAX) begin
                    units_nxt = 4'd0;
                    if (tens == BCD_MAX) begin
                        tens_nxt = 4'd0;
                        wrap_nxt = 1'b1;
                    end else begin
                        tens_nxt = tens + 4'd1;
                    end
                end else begin
                    units_nxt = units + 4'd1;
                end
            end else begin
                if (units == 4'd0) begin
                    units_nxt = BCD_MAX;
                    if (tens == 4'd0) begin
                        tens_nxt = BCD_MAX;
                        wrap_nxt = 1'b1;
                    end else begin
                        tens_nxt = tens - 4'd1;
                    end
                end else begin
                    units_nxt = units - 4'd1;
                end
            end
        end
    end

    // Count, wrap pulse and registered running flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            units   <= 4'd0;
            tens    <= 4'd0;
            wrap    <= 1'b0;
            running <= 1'b0;
        end else begin
            running <= (state_nxt == RUN);
            if (clear) begin
                units <= 4'd0;
                tens  <= 4'd0;
                wrap  <= 1'b0;
            end else begin
                units <= units_nxt;
                tens  <= tens_nxt;
                wrap  <= wrap_nxt;
            end
        end
    end

    assign scan_edge = (scan_cnt == SCAN_LAST);

    // Free-running digit scan; bcd_out is loaded together with dig_sel so they always match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig_sel  <= DIG_UNITS;
            bcd_out  <= 4'd0;
        end else if (scan_edge) begin
            scan_cnt <= '0;
            if (dig_sel == DIG_UNITS) begin
                dig_sel <= DIG_TENS;
                bcd_out <= tens;
            end else begin
                dig_sel <= DIG_UNITS;
                bcd_out <= units;
            end
        end else begin
            scan_cnt <= scan_cnt + SW'(1);
        end
    end

endmodule

// File: tb/tb_contador_bcd_mux.sv
// Scoreboard bench: a decimal reference model predicts every cycle's outputs into a queue,
// and a monitor compares the DUT against the queue shortly after each clock edge.
module tb_contador_bcd_mux;

    localparam int PRESCALE = 4;
    localparam int SCAN_DIV = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, clear = 1'b0, up_dn = 1'b1;
    logic [3:0] bcd_out;
    logic [1:0] dig_sel;
    logic       running;
    logic       wrap;

    typedef struct {
        logic [3:0] bcd;
        logic [1:0] sel;
        logic       run;
        logic       wrp;
    } exp_t;

    exp_t exp_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state: count as a plain number 0..99.
    int m_st = M_IDLE, m_cnt = 0, m_phase = 0, m_scan = 0, m_sel = 0, m_disp = 0;
    bit m_wrap = 0;

    contador_bcd_mux #(.PRESCALE(PRESCALE), .SCAN_DIV(SCAN_DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .clear   (clear),
        .up_dn   (up_dn),
        .bcd_out (bcd_out),
        .dig_sel (dig_sel),
        .running (running),
        .wrap    (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, advanced on every clock edge using the inputs sampled at that edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = M_IDLE; m_cnt = 0; m_phase = 0; m_scan = 0; m_sel = 0; m_disp = 0; m_wrap = 0;
        end else begin
            exp_t e;
            int   old_st;
            // Display refresh shows the count as it was before this edge.
            m_scan++;
            if (m_scan == SCAN_DIV) begin
                m_scan = 0;
                m_sel  = 1 - m_sel;
                m_disp = (m_sel == 1) ? m_cnt / 10 : m_cnt % 10;
            end
            old_st = m_st;
            m_wrap = 0;
            if (clear) begin
                m_st = M_IDLE; m_cnt = 0; m_phase = 0;
            end else if (stop) begin
                if (old_st == M_RUN) m_st = M_PAUSE;
            end else begin
                if (old_st == M_RUN) begin
                    if (m_phase == PRESCALE - 1) begin
                        m_phase = 0;
                        if (up_dn) begin
                            m_wrap = (m_cnt == 99);
                            m_cnt  = (m_cnt + 1) % 100;
                        end else begin
                            m_wrap = (m_cnt == 0);
                            m_cnt  = (m_cnt + 99) % 100;
                        end
                    end else begin
                        m_phase++;
                    end
                end
                if (start && old_st != M_RUN) m_st = M_RUN;
            end
            e.bcd = 4'(m_disp);
            e.sel = (m_sel == 0) ? 2'b10 : 2'b01;
            e.run = (m_st == M_RUN);
            e.wrp = m_wrap;
            exp_q.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the oldest prediction, away from the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("bcd_out", int'(bcd_out), int'(e.bcd));
            chk("dig_sel", int'(dig_sel), int'(e.sel));
            chk("running", int'(running), int'(e.run));
            chk("wrap",    int'(wrap),    int'(e.wrp));
        end
    end

    task automatic drive(input bit s, input bit p, input bit c, input bit u, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = s; stop = p; clear = c; up_dn = u;
        end
    endtask

    task automatic drive_random(input int n, input bit allow_start);
        bit u;
        u = up_dn;
        for (int i = 0; i < n; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 29) == 0) u = ~u;
            @(negedge clk);
            clear = (r < 2);
            stop  = (r >= 2 && r < 7);
            start = allow_start && (r >= 7 && r < 19);
            if (r == 99) begin clear = 1; stop = 1; start = allow_start; end
            up_dn = u;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_bcd"},  int'(bcd_out), 0);
        chk({tag, "_sel"},  int'(dig_sel), 2);
        chk({tag, "_run"},  int'(running), 0);
        chk({tag, "_wrap"}, int'(wrap),    0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check_reset_values("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with no start: must stay idle.
        drive(0, 0, 0, 0, 5);
        drive(0, 1, 0, 1, 2);
        // Single start pulse, count up 00 -> 03.
        drive(1, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 13);
        // Down through 00 -> 99 -> 98, then up through 99 -> 00.
        drive(0, 0, 0, 0, 22);
        drive(0, 0, 0, 1, 12);
        // Clear, then up past 09 -> 10, then down 10 -> 09.
        drive(0, 0, 1, 1, 1);
        drive(1, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 42);
        drive(0, 0, 0, 0, 4);
        // Pause mid-period, hold, resume.
        drive(0, 0, 0, 1, 2);
        drive(0, 1, 0, 1, 1);
        drive(0, 0, 0, 1, 6);
        drive(1, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 8);
        // Stop asserted while start is also high in RUN.
        drive(1, 1, 0, 1, 1);
        drive(1, 0, 0, 1, 6);
        // All three at once: clear wins.
        drive(1, 1, 1, 1, 1);
        drive(0, 0, 0, 1, 6);

        drive_random(2000, 1'b1);

        // Reach 45 in RUN, then reset asynchronously mid-cycle.
        drive(0, 0, 1, 1, 1);
        drive(1, 0, 0, 1, 1);
        begin
            int guard;
            guard = 0;
            while (m_cnt != 45 && guard < 1000) begin
                drive(0, 0, 0, 1, 1);
                guard++;
            end
            chk("reach45_timeout", guard < 1000 ? 1 : 0, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_random(40, 1'b0);
        drive(0, 0, 0, 1, 3);

        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/contador_bcd_mux.md
CONTADOR_BCD_MUX -- requirements
Module: contador_bcd_mux

Interface
REQ-001 SHALL have parameter PRESCALE, default 4: clk cycles per count tick; legal range is 2 or more.
REQ-002 SHALL have parameter SCAN_DIV, default 2: clk cycles each digit stays selected; legal range is 1 or more.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  synchronous level; requests counting.
REQ-006 stop  input  1  synchronous level; requests pause.
REQ-007 clear  input  1  synchronous level; return to IDLE with count 00.
REQ-008 up_dn  input  1  1 = count up, 0 = count down; sampled only on a tick.
REQ-009 bcd_out  output  4  BCD digit for the external 7-segment decoder; bit 3 is MSB (decoder input A).
REQ-010 dig_sel  output  2  active-low digit enable: 2'b10 = units, 2'b01 = tens.
REQ-011 running  output  1  high while FSM is in RUN.
REQ-012 wrap  output  1  one-cycle pulse on 99->00 (up) or 00->99 (down).

Function
REQ-013 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-014 Input priority SHALL be clear > stop > start when more than one is sampled high in the same cycle.
REQ-015 clear in any state SHALL go to IDLE next cycle, with count 00 and prescaler 0.
REQ-016 start in IDLE or PAUSE (clear and stop low) SHALL go to RUN next cycle; start in RUN SHALL have no effect.
REQ-017 stop in RUN (clear low) SHALL go to PAUSE next cycle; stop in IDLE or PAUSE SHALL have no effect.
REQ-018 Prescaler SHALL count 0..PRESCALE-1 in RUN only and hold its value in PAUSE; RUN entered from IDLE starts from 0.
REQ-019 Tick SHALL be asserted in the cycle the prescaler equals PRESCALE-1 in RUN; the prescaler then returns to 0.
REQ-020 Count SHALL be held as two BCD digits (tens, units), each 0..9, never holding 10..15.
REQ-021 On a tick with up_dn=1: units 9->0 with a carry into tens, else units+1; tens 9->0 on carry.
REQ-022 On a tick with up_dn=0: units 0->9 with a borrow from tens, else units-1; tens 0->9 on borrow.
REQ-023 Count SHALL update on the clock edge ending the tick cycle (latency 1).
REQ-024 wrap SHALL be high for exactly the cycle after the 99->00 or 00->99 update.
REQ-025 stop or clear sampled in the tick cycle SHALL suppress that count update and wrap.
REQ-026 running SHALL be a registered decode of the FSM state and SHALL go high the cycle RUN is entered.
REQ-027 Scan counter SHALL run freely in all states and toggle the selected digit every SCAN_DIV cycles.
REQ-028 dig_sel and bcd_out SHALL be registered, and bcd_out SHALL carry the digit selected by dig_sel in the same cycle.
REQ-029 A count update SHALL appear on bcd_out at the next scan edge of that digit.

Reset
REQ-030 While rst_n is low: state=IDLE, count=00, prescaler=0, scan counter=0, dig_sel=2'b10, bcd_out=4'h0, running=0, wrap=0.
REQ-031 Reset asserted mid-RUN SHALL abort immediately, with no wrap pulse.
REQ-032 After rst_n deasserts, the block SHALL stay in IDLE until start is sampled.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/RUN/PAUSE), the dig_sel codes DIG_UNITS=2'b10 and DIG_TENS=2'b01, and BCD_MAX=4'd9.
REQ-034 The prescaler SHALL be a separate sub-module, contador_prescaler (ports: clk, rst_n, en, sync_clr, tick).
REQ-035 The BCD-to-7-segment decode SHALL stay outside this block.

Verification
REQ-036 Reset then start for 1 cycle, PRESCALE=4: running=1 the next cycle; count 00->01->02 on every 4th cycle; wrap stays 0.
REQ-037 Preload 98, up_dn=1: two ticks give 99 then 00; wrap=1 for one cycle only; with up_dn=0 from 00 the count goes to 99 and wrap pulses.
REQ-038 Count 09 up gives 10; count 10 down gives 09; no digit ever exceeds 9.
REQ-039 stop in RUN with prescaler=2: PAUSE, count held; start resumes with the first tick 1 cycle later; clear+stop+start together gives IDLE, count 00.
REQ-040 SCAN_DIV=2, count 37: dig_sel alternates 10/01 every 2 cycles with bcd_out 7/3 aligned, including during IDLE.
REQ-041 rst_n low mid-RUN at count 45: all outputs reach reset values asynchronously; after release the block stays in IDLE, displays 00 and has running=0.
